instr_fetch: RTL

- Instruction fetch stage plus IF/ID pipeline register for the simplified MIPS core.
- Owns the PC and issues requests to instruction memory over a valid/ready-style handshake.
- Applies stalls and branch/jump redirects, and presents the fetched instruction and its opcode to the main control decoder and the ID stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 34 +++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, NOP, reset PC and fetch state encoding
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_SQUASH = 2'd3;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc4_in,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc4
);

  // flush wins over load; a flush keeps pc4 and only kills the instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= W'(NOP);
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= W'(NOP);
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM, PC/redirect logic and imem handshake
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  output logic                if_id_valid,
  output logic [PC_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic [5:0]          opcode
);

  logic [1:0]          state, state_nx;
  logic [PC_WIDTH-1:0] pc, pc_nx;
  logic [PC_WIDTH-1:0] req_addr, req_addr_nx;
  logic [PC_WIDTH-1:0] hold_buf, hold_buf_nx;
  logic                issued, issued_nx;
  logic [PC_WIDTH-1:0] raw_target, target, addr_inc;
  logic                redirect, resp;
  logic                ifid_load, ifid_flush;
  logic [PC_WIDTH-1:0] ifid_instr_in;

  assign redirect   = branch_taken | (jump & if_id_valid);
  assign raw_target = branch_taken ? branch_target
                                   : {if_id_pc4[PC_WIDTH-1:28], if_id_instr[25:0], 2'b00};
  assign target     = raw_target & ~PC_WIDTH'(3);
  assign addr_inc   = req_addr + PC_WIDTH'(4);

  // issued marks that the current request has been on the bus for at least one
  // cycle, so imem_ready in the very first request cycle is never taken as a reply
  assign resp      = (state == ST_FETCH) & issued & imem_ready;
  assign imem_req  = (state == ST_FETCH) | (state == ST_SQUASH);
  assign imem_addr = ((state == ST_FETCH) && !issued) ? pc : req_addr;

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    req_addr_nx   = req_addr;
    hold_buf_nx   = hold_buf;
    issued_nx     = issued;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = imem_rdata;
    case (state)
      ST_BOOT: begin
        state_nx  = ST_FETCH;
        issued_nx = 1'b0;
      end
      ST_FETCH: begin
        if (!issued) req_addr_nx = pc;
        issued_nx = 1'b1;
        if (redirect) begin
          pc_nx      = target;
          ifid_flush = 1'b1;
          if (resp) issued_nx = 1'b0;
          else      state_nx  = ST_SQUASH;
        end else if (resp && !stall) begin
          ifid_load = 1'b1;
          pc_nx     = addr_inc;
          issued_nx = 1'b0;
        end else if (resp) begin
          hold_buf_nx = imem_rdata;
          state_nx    = ST_HOLD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_nx      = target;
          ifid_flush = 1'b1;
          state_nx   = ST_FETCH;
          issued_nx  = 1'b0;
        end else if (!stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = hold_buf;
          pc_nx         = addr_inc;
          state_nx      = ST_FETCH;
          issued_nx     = 1'b0;
        end
      end
      ST_SQUASH: begin
        // the old request stays on the bus until memory answers; its data is dropped
        if (redirect) begin
          pc_nx      = target;
          ifid_flush = 1'b1;
        end
        if (imem_ready) begin
          state_nx  = ST_FETCH;
          issued_nx = 1'b0;
        end
      end
      default: begin
        state_nx  = ST_BOOT;
        issued_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      hold_buf <= PC_WIDTH'(NOP);
      issued   <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      hold_buf <= hold_buf_nx;
      issued   <= issued_nx;
    end
  end

  if_id_reg #(.W(PC_WIDTH)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (ifid_instr_in),
    .pc4_in   (addr_inc),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4)
  );

  assign opcode = if_id_instr[PC_WIDTH-1:PC_WIDTH-6];

endmodule
